// File: rtl/fa_nbits_pipe_if.sv
// fa_nbits_pipe_if: operand/result handshake bundle for fa_nbits_pipe.
//   master : operand source and result consumer side
//   slave  : adder pipeline side
//   in_valid/in_ready  operand transfer, port_a/port_b/cin/sub operands
//   out_valid/out_ready result transfer, port_sum/port_cout/ovf result
interface fa_nbits_pipe_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  fa_pipe_in_valid;
   logic                  fa_pipe_in_ready;
   logic [DATA_WIDTH-1:0] fa_pipe_port_a;
   logic [DATA_WIDTH-1:0] fa_pipe_port_b;
   logic                  fa_pipe_cin;
   logic                  fa_pipe_sub;
   logic                  fa_pipe_out_valid;
   logic                  fa_pipe_out_ready;
   logic [DATA_WIDTH-1:0] fa_pipe_port_sum;
   logic                  fa_pipe_port_cout;
   logic                  fa_pipe_ovf;

   modport master (
      output fa_pipe_in_valid, fa_pipe_port_a, fa_pipe_port_b, fa_pipe_cin,
             fa_pipe_sub, fa_pipe_out_ready,
      input  fa_pipe_in_ready, fa_pipe_out_valid, fa_pipe_port_sum,
             fa_pipe_port_cout, fa_pipe_ovf
   );

   modport slave (
      input  fa_pipe_in_valid, fa_pipe_port_a, fa_pipe_port_b, fa_pipe_cin,
             fa_pipe_sub, fa_pipe_out_ready,
      output fa_pipe_in_ready, fa_pipe_out_valid, fa_pipe_port_sum,
             fa_pipe_port_cout, fa_pipe_ovf
   );
endinterface

// File: rtl/fa_nbits_pipe.sv
// fa_nbits_pipe: pipelined N-bit adder/subtractor. The carry chain is cut
// into STAGES chunks of W = DATA_WIDTH/STAGES bits; stage k adds chunk k and
// registers it with the carry for stage k+1. One result per clock, global
// stall when the result is held by the consumer.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : fa_nbits_pipe_if.slave (operands in, result/cout/ovf out)
module fa_nbits_pipe #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned STAGES     = 2
) (
   input logic            clk,
   input logic            rst,
   fa_nbits_pipe_if.slave bus
);
   localparam int unsigned W = DATA_WIDTH / STAGES;

   if (DATA_WIDTH < 2 || STAGES < 1 || STAGES > DATA_WIDTH ||
       (DATA_WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("fa_nbits_pipe: illegal DATA_WIDTH/STAGES combination");
   end

   // Per-stage registers: operands travel with the data (B already
   // mode-inverted), s_q collects completed chunks, c_q is the chunk carry.
   logic [DATA_WIDTH-1:0] a_q [STAGES];
   logic [DATA_WIDTH-1:0] b_q [STAGES];
   logic [DATA_WIDTH-1:0] s_q [STAGES];
   logic                  c_q [STAGES];
   logic                  v_q [STAGES];
   logic                  ovf_q;

   logic [DATA_WIDTH-1:0] a_d [STAGES];
   logic [DATA_WIDTH-1:0] b_d [STAGES];
   logic [DATA_WIDTH-1:0] s_d [STAGES];
   logic                  c_d [STAGES];
   logic                  v_d [STAGES];
   logic                  ovf_d;

   logic                  advance;
   logic [DATA_WIDTH-1:0] op_a, op_b, op_s;
   logic                  op_c, op_v;
   logic [W:0]            chunk;

   always_comb begin
      advance = !v_q[STAGES-1] || bus.fa_pipe_out_ready;
      ovf_d   = 1'b0;
      op_a    = '0;
      op_b    = '0;
      op_s    = '0;
      op_c    = 1'b0;
      op_v    = 1'b0;
      chunk   = '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
         if (k == 0) begin
            // Subtract folds into an add here: A + ~B + ~cin.
            op_a = bus.fa_pipe_port_a;
            op_b = bus.fa_pipe_port_b ^ {DATA_WIDTH{bus.fa_pipe_sub}};
            op_c = bus.fa_pipe_cin ^ bus.fa_pipe_sub;
            op_s = '0;
            op_v = bus.fa_pipe_in_valid;
         end else begin
            op_a = a_q[k-1];
            op_b = b_q[k-1];
            op_c = c_q[k-1];
            op_s = s_q[k-1];
            op_v = v_q[k-1];
         end
         chunk = {1'b0, op_a[k*W +: W]} + {1'b0, op_b[k*W +: W]} + {{W{1'b0}}, op_c};
         a_d[k] = op_a;
         b_d[k] = op_b;
         s_d[k] = op_s;
         s_d[k][k*W +: W] = chunk[W-1:0];
         c_d[k] = chunk[W];
         v_d[k] = op_v;
         // Carry into the MSB is recovered from the MSB sum bit and its
         // operands, so the overflow needs no extra split of the last chunk.
         if (k == STAGES - 1) begin
            ovf_d = chunk[W] ^ chunk[W-1] ^ op_a[DATA_WIDTH-1] ^ op_b[DATA_WIDTH-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
            c_q[k] <= 1'b0;
            v_q[k] <= 1'b0;
         end
         ovf_q <= 1'b0;
      end else if (advance) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
            s_q[k] <= s_d[k];
            c_q[k] <= c_d[k];
            v_q[k] <= v_d[k];
         end
         ovf_q <= ovf_d;
      end
   end

   assign bus.fa_pipe_in_ready  = advance;
   assign bus.fa_pipe_out_valid = v_q[STAGES-1];
   assign bus.fa_pipe_port_sum  = s_q[STAGES-1];
   assign bus.fa_pipe_port_cout = c_q[STAGES-1];
   assign bus.fa_pipe_ovf       = ovf_q;
endmodule

// File: tb/tb_fa_nbits_pipe.sv
// tb_fa_nbits_pipe: drives three fa_nbits_pipe instances (STAGES = 1, 2, 8)
// from one operand source; each instance keeps its own expected-result queue.
// Directed timing checks (latency, stall, reset) look at the STAGES=2 one.
module tb_fa_nbits_pipe;
   localparam int unsigned DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          drv_valid, drv_cin, drv_sub, out_rdy;
   logic [DW-1:0] drv_a, drv_b;
   logic          chk_drain;
   int unsigned   n_checks = 0;
   int unsigned   n_fail   = 0;

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: {sum, cout, ovf}; overflow by the sign rule.
   function automatic logic [DW+1:0] model(input logic [DW-1:0] a, b, input logic ci, sb);
      logic [DW-1:0] be;
      logic          ce;
      logic [DW:0]   full;
      logic          ov;
      be   = sb ? ~b : b;
      ce   = sb ? ~ci : ci;
      full = {1'b0, a} + {1'b0, be} + {{DW{1'b0}}, ce};
      ov   = (a[DW-1] == be[DW-1]) && (full[DW-1] != a[DW-1]);
      return {full[DW-1:0], full[DW], ov};
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned ST = (g == 0) ? 1 : ((g == 1) ? 2 : 8);
      fa_nbits_pipe_if #(.DATA_WIDTH(DW)) bus ();
      fa_nbits_pipe #(.DATA_WIDTH(DW), .STAGES(ST)) dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );
      assign bus.fa_pipe_in_valid  = drv_valid;
      assign bus.fa_pipe_port_a    = drv_a;
      assign bus.fa_pipe_port_b    = drv_b;
      assign bus.fa_pipe_cin       = drv_cin;
      assign bus.fa_pipe_sub       = drv_sub;
      assign bus.fa_pipe_out_ready = out_rdy;

      logic [DW+1:0] q [$];
      logic [DW+1:0] exp_v;

      always @(negedge clk) begin
         if (rst) begin
            q.delete();
         end else begin
            if (bus.fa_pipe_out_valid && bus.fa_pipe_out_ready) begin
               if (q.size() == 0) begin
                  check($sformatf("st%0d_spurious", ST), {31'd0, bus.fa_pipe_out_valid}, 32'd0);
               end else begin
                  exp_v = q.pop_front();
                  check($sformatf("st%0d_result", ST),
                        {22'd0, bus.fa_pipe_port_sum, bus.fa_pipe_port_cout, bus.fa_pipe_ovf},
                        {22'd0, exp_v});
               end
            end
            if (bus.fa_pipe_in_valid && bus.fa_pipe_in_ready)
               q.push_back(model(bus.fa_pipe_port_a, bus.fa_pipe_port_b,
                                 bus.fa_pipe_cin, bus.fa_pipe_sub));
            if (chk_drain)
               check($sformatf("st%0d_drain", ST), q.size(), 32'd0);
         end
      end
   end

   // Throughput monitor on the STAGES=2 instance.
   logic        cnt_en;
   int unsigned cyc = 0, n_out = 0, first_cyc = 0, last_cyc = 0;
   always @(negedge clk) begin
      cyc++;
      if (cnt_en && g_dut[1].bus.fa_pipe_out_valid && g_dut[1].bus.fa_pipe_out_ready) begin
         if (n_out == 0) first_cyc = cyc;
         last_cyc = cyc;
         n_out++;
      end
   end

   task automatic send(input logic [DW-1:0] a, b, input logic ci, sb);
      drv_a = a; drv_b = b; drv_cin = ci; drv_sub = sb; drv_valid = 1'b1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (g_dut[1].bus.fa_pipe_in_ready) break;
      end
      if (!g_dut[1].bus.fa_pipe_in_ready)
         check("send_timeout", {31'd0, g_dut[1].bus.fa_pipe_in_ready}, 32'd1);
      @(posedge clk); #1;
      drv_valid = 1'b0;
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   logic [DW+1:0] held;

   initial begin
      rst = 1'b1; out_rdy = 1'b1; drv_valid = 1'b0; chk_drain = 1'b0; cnt_en = 1'b0;
      drv_a = '0; drv_b = '0; drv_cin = 1'b0; drv_sub = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", {31'd0, g_dut[1].bus.fa_pipe_out_valid}, 32'd0);
      check("rst_sum",       {24'd0, g_dut[1].bus.fa_pipe_port_sum}, 32'd0);
      check("rst_cout",      {31'd0, g_dut[1].bus.fa_pipe_port_cout}, 32'd0);
      check("rst_ovf",       {31'd0, g_dut[1].bus.fa_pipe_ovf}, 32'd0);
      check("rst_in_ready",  {31'd0, g_dut[1].bus.fa_pipe_in_ready}, 32'd1);
      @(posedge clk); #1;

      // Latency: result visible two cycles after the operands are presented.
      send(8'h05, 8'h0E, 1'b0, 1'b0);
      @(negedge clk);
      check("lat_early", {31'd0, g_dut[1].bus.fa_pipe_out_valid}, 32'd0);
      @(negedge clk);
      check("lat_valid", {31'd0, g_dut[1].bus.fa_pipe_out_valid}, 32'd1);
      check("lat_sum",   {24'd0, g_dut[1].bus.fa_pipe_port_sum}, 32'h13);
      @(posedge clk); #1;

      // Boundary vectors: chunk-crossing carry, signed overflow, borrow.
      send(8'hFF, 8'h01, 1'b0, 1'b0);
      send(8'h7F, 8'h01, 1'b0, 1'b0);
      send(8'h05, 8'h0E, 1'b0, 1'b1);
      send(8'h80, 8'h01, 1'b0, 1'b1);
      send(8'h10, 8'h00, 1'b1, 1'b1);
      idle(12);

      // Back-to-back random stream.
      cnt_en = 1'b1; n_out = 0;
      for (int i = 0; i < 8; i++)
         send(DW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom));
      idle(12);
      cnt_en = 1'b0;
      check("stream_count", n_out, 32'd8);
      check("stream_span",  last_cyc - first_cyc, 32'd7);

      // Stall with a full pipeline and a pending operand set.
      out_rdy = 1'b0;
      send(8'h3C, 8'h11, 1'b0, 1'b0);
      send(8'hA0, 8'h60, 1'b1, 1'b0);
      drv_a = 8'h55; drv_b = 8'h2A; drv_cin = 1'b0; drv_sub = 1'b1; drv_valid = 1'b1;
      @(negedge clk);
      held = {g_dut[1].bus.fa_pipe_port_sum, g_dut[1].bus.fa_pipe_port_cout, g_dut[1].bus.fa_pipe_ovf};
      check("stall_in_ready", {31'd0, g_dut[1].bus.fa_pipe_in_ready}, 32'd0);
      repeat (2) begin
         @(negedge clk);
         check("stall_in_ready", {31'd0, g_dut[1].bus.fa_pipe_in_ready}, 32'd0);
         check("stall_valid",    {31'd0, g_dut[1].bus.fa_pipe_out_valid}, 32'd1);
         check("stall_hold",
               {22'd0, g_dut[1].bus.fa_pipe_port_sum, g_dut[1].bus.fa_pipe_port_cout, g_dut[1].bus.fa_pipe_ovf},
               {22'd0, model(8'h3C, 8'h11, 1'b0, 1'b0)});
      end
      check("stall_first", {22'd0, held}, {22'd0, model(8'h3C, 8'h11, 1'b0, 1'b0)});
      @(posedge clk); #1;
      out_rdy = 1'b1;
      @(negedge clk);
      check("release_ready", {31'd0, g_dut[1].bus.fa_pipe_in_ready}, 32'd1);
      @(posedge clk); #1;
      drv_valid = 1'b0;
      idle(12);
      chk_drain = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      chk_drain = 1'b0;

      // Reset with operations in flight.
      send(8'h12, 8'h34, 1'b0, 1'b0);
      send(8'hF0, 8'h0F, 1'b1, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst1_valid", {31'd0, g_dut[0].bus.fa_pipe_out_valid}, 32'd0);
      check("rst1_out",   {22'd0, g_dut[0].bus.fa_pipe_port_sum, g_dut[0].bus.fa_pipe_port_cout, g_dut[0].bus.fa_pipe_ovf}, 32'd0);
      check("rst2_valid", {31'd0, g_dut[1].bus.fa_pipe_out_valid}, 32'd0);
      check("rst2_out",   {22'd0, g_dut[1].bus.fa_pipe_port_sum, g_dut[1].bus.fa_pipe_port_cout, g_dut[1].bus.fa_pipe_ovf}, 32'd0);
      check("rst8_valid", {31'd0, g_dut[2].bus.fa_pipe_out_valid}, 32'd0);
      check("rst8_out",   {22'd0, g_dut[2].bus.fa_pipe_port_sum, g_dut[2].bus.fa_pipe_port_cout, g_dut[2].bus.fa_pipe_ovf}, 32'd0);
      // Any stale result now shows up as a spurious output in the monitors.
      idle(14);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/fa_nbits_pipe.md
# fa_nbits_pipe

Parametrised, pipelined N-bit adder/subtractor that generalises the lab full-adder chain into a registered datapath with a valid/ready handshake. The carry chain is split into `STAGES` equal chunks, each computed in its own pipeline stage, so wide adds close timing on the NEXYS A7 100T at one result per clock. It sits between operand sources (switch/register logic) and result consumers (seven-segment/LED drivers, accumulators) and reports carry-out and signed overflow with every result.

## Interface
- `DATA_WIDTH`, 8, operand/sum width in bits; must be ≥ 2.
- `STAGES`, 2, pipeline depth and number of carry-chain chunks; 1 ≤ `STAGES` ≤ `DATA_WIDTH`; `DATA_WIDTH % STAGES == 0` is required (elaboration error otherwise). Chunk width `W = DATA_WIDTH/STAGES`.

- `clk`  in  1  single system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fa_pipe_in_valid`  in  1  operand set presented.
- `fa_pipe_in_ready`  out  1  block can accept operands this cycle.
- `fa_pipe_port_a`  in  DATA_WIDTH  operand A (unsigned or two's complement).
- `fa_pipe_port_b`  in  DATA_WIDTH  operand B.
- `fa_pipe_cin`  in  1  carry-in (add) / borrow-in (subtract).
- `fa_pipe_sub`  in  1  0 = add, 1 = subtract.
- `fa_pipe_out_valid`  out  1  result registers hold a valid result.
- `fa_pipe_out_ready`  in  1  consumer accepts result this cycle.
- `fa_pipe_port_sum`  out  DATA_WIDTH  result.
- `fa_pipe_port_cout`  out  1  carry out of MSB.
- `fa_pipe_ovf`  out  1  signed (two's-complement) overflow.

## Operation
- Add (`sub=0`): `{cout,sum} = A + B + cin`.
- Subtract (`sub=1`): `{cout,sum} = A + ~B + ~cin`, i.e. `A − B − cin`; `cout=1` means no borrow, `cout=0` means borrow.
- `ovf = carry into MSB XOR carry out of MSB`; valid in both modes.
- Stage k (0..STAGES−1) adds bits `[k*W +: W]` with the carry registered from stage k−1 (stage 0 uses effective carry-in). Unprocessed operand bits and completed sum bits travel with the data in stage registers; per-stage valid bit.
- `sub` inversion of B and cin is applied before stage 0 registration; no later stage sees mode.
- Transfer in: `in_valid && in_ready`. Transfer out: `out_valid && out_ready`.
- Global stall: `advance = !out_valid || out_ready`; `in_ready = advance`. When `advance=0`, every stage register (data and valid) holds. When `advance=1`, all stages shift; a stage with no incoming transfer loads valid=0 (bubble).
- Results leave in acceptance order; no reordering, no drop, no duplication.
- Outputs `sum/cout/ovf` are don't-care-stable: they hold the last stage's register and change only on `advance`.

## Timing
- Reset (`rst=1` at a rising edge): all valid bits → 0; `out_valid=0`, `sum=0`, `cout=0`, `ovf=0`. `in_ready=1` in the first cycle after reset. Reset has priority over every transfer; in-flight operations are discarded, nothing emerges afterward.
- Latency: operands accepted at edge t → result on outputs with `out_valid=1` after edge t+STAGES (with no stalls). `STAGES=1` → single registered adder, 1-cycle latency.
- Throughput: one result per cycle while `out_ready=1`.
- Stall: each cycle with `out_valid=1 && out_ready=0` adds exactly one cycle to all in-flight latencies; `in_ready` is combinationally low in that cycle.
- Simultaneous out-transfer and in-transfer in the same cycle is legal and loses nothing.
- `in_valid` while `in_ready=0`: operands ignored; source must hold them.
- Wrap-around: sums modulo 2^DATA_WIDTH; carry out reported, never saturated.

## Test plan
- DW=8, ST=2, add A=0x05, B=0x0E, cin=0 → 2 cycles later sum=0x13, cout=0, ovf=0.
- Add A=0xFF, B=0x01, cin=0 → sum=0x00, cout=1, ovf=0 (carry crosses chunk boundary); A=0x7F, B=0x01 → sum=0x80, cout=0, ovf=1.
- Sub A=0x05, B=0x0E, cin=0 → sum=0xF7, cout=0, ovf=0; A=0x80, B=0x01 → sum=0x7F, cout=1, ovf=1; A=0x10, B=0x00, cin=1 → sum=0x0F, cout=1.
- Back-to-back stream of 8 random operand sets, `out_ready=1` → 8 consecutive valid results in order matching reference model, one per cycle.
- Hold `out_ready=0` for 3 cycles with pipeline full → `in_ready=0`, outputs unchanged; release → results resume in order, none lost or duplicated.
- Assert `rst` with 2 operations in flight → next cycle `out_valid=0`, all outputs 0; no stale result ever appears. Repeat with ST=1 and ST=8 (W=1).
